// File: rtl/cpu_multicycle_if.sv
// Instruction-fetch and data-access handshake bundle of the multicycle core.
// The core drives the request side (master); the memories drive the response side (slave).
interface cpu_multicycle_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_valid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_valid, imem_rdata, dmem_valid, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_valid, imem_rdata, dmem_valid, dmem_rdata
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle 16-register core: FETCH/DECODE/EXEC/MEM/WB/HALT with req/valid memory handshakes.
// Control outputs are registered from the next state so they are low in the reset cycle.
module cpu_multicycle #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int unsigned     PC_STEP  = 4,
    parameter bit              ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    cpu_multicycle_if.master bus,
    output logic [XLEN-1:0]  pc,
    output logic             retire,
    output logic             halted
);
    localparam int              SHW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8,  OP_SW  = 4'd9,  OP_BEQ = 4'd10, OP_BNE  = 4'd11;
    localparam logic [3:0] OP_JAL = 4'd12, OP_JR  = 4'd13, OP_LUI = 4'd14, OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_npc;
    logic [XLEN-1:0] r_regs [0:15];
    logic            r_imem_req;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_retire;
    logic            r_halted;

    logic [3:0]      w_op;
    logic [3:0]      w_rd;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_npc;
    logic [XLEN-1:0] w_rd_a;
    logic [XLEN-1:0] w_rd_b;
    logic            w_writes;
    logic            w_wen;
    logic            w_ifire;
    logic            w_dfire;

    assign w_op    = r_ir[31:28];
    assign w_rd    = r_ir[27:24];
    assign w_ra    = r_ir[23:20];
    assign w_rb    = r_ir[19:16];
    assign w_imm   = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
    assign w_ifire = r_imem_req && bus.imem_valid;
    assign w_dfire = r_dmem_req && bus.dmem_valid;
    assign w_wen   = w_writes && !(ZERO_REG && (w_rd == 4'd0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_ifire) w_next = S_DECODE; else w_next = S_FETCH;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   if ((w_op == OP_LW) || (w_op == OP_SW)) w_next = S_MEM; else w_next = S_WB;
            S_MEM:    if (w_dfire) w_next = S_WB; else w_next = S_MEM;
            S_WB:     if (w_op == OP_HALT) w_next = S_HALT; else w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Register-file read with the optional hard-wired zero register
    always_comb begin
        if (ZERO_REG && (w_ra == 4'd0)) w_rd_a = {XLEN{1'b0}}; else w_rd_a = r_regs[w_ra];
        if (ZERO_REG && (w_rb == 4'd0)) w_rd_b = {XLEN{1'b0}}; else w_rd_b = r_regs[w_rb];
    end

    // ALU result, next PC and register-write qualifier; offsets are relative to the branch PC
    always_comb begin
        w_alu    = {XLEN{1'b0}};
        w_npc    = r_pc + STEP;
        w_writes = 1'b0;
        case (w_op)
            OP_ADD:  begin w_alu = r_a + r_b;            w_writes = 1'b1; end
            OP_SUB:  begin w_alu = r_a - r_b;            w_writes = 1'b1; end
            OP_AND:  begin w_alu = r_a & r_b;            w_writes = 1'b1; end
            OP_OR:   begin w_alu = r_a | r_b;            w_writes = 1'b1; end
            OP_XOR:  begin w_alu = r_a ^ r_b;            w_writes = 1'b1; end
            OP_SLL:  begin w_alu = r_a << r_b[SHW-1:0];  w_writes = 1'b1; end
            OP_SRL:  begin w_alu = r_a >> r_b[SHW-1:0];  w_writes = 1'b1; end
            OP_ADDI: begin w_alu = r_a + w_imm;          w_writes = 1'b1; end
            OP_LW:   begin w_alu = r_a + w_imm;          w_writes = 1'b1; end
            OP_SW:   w_alu = r_a + w_imm;
            OP_BEQ:  if (r_a == r_b) w_npc = r_pc + w_imm; else w_npc = r_pc + STEP;
            OP_BNE:  if (r_a != r_b) w_npc = r_pc + w_imm; else w_npc = r_pc + STEP;
            OP_JAL:  begin w_alu = r_pc + STEP; w_npc = r_pc + w_imm; w_writes = 1'b1; end
            OP_JR:   w_npc = r_a;
            OP_LUI:  begin w_alu = {{(XLEN-32){1'b0}}, r_ir[15:0], 16'h0000}; w_writes = 1'b1; end
            OP_HALT: w_npc = r_pc;
            default: w_npc = r_pc + STEP;
        endcase
    end

    // Registered handshake and status outputs, derived from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_retire   <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_imem_req <= (w_next == S_FETCH);
            r_dmem_req <= (w_next == S_MEM);
            r_dmem_we  <= (w_next == S_MEM) && (w_op == OP_SW);
            r_retire   <= (w_next == S_WB);
            r_halted   <= (w_next == S_HALT);
        end
    end

    // Datapath registers and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= 32'h0000_0000;
            r_a   <= {XLEN{1'b0}};
            r_b   <= {XLEN{1'b0}};
            r_alu <= {XLEN{1'b0}};
            r_npc <= {XLEN{1'b0}};
            for (int i = 0; i < 16; i++) r_regs[i] <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_FETCH:  if (w_ifire) r_ir <= bus.imem_rdata;
                S_DECODE: begin r_a <= w_rd_a; r_b <= w_rd_b; end
                S_EXEC:   begin r_alu <= w_alu; r_npc <= w_npc; end
                S_MEM:    if (w_dfire && !r_dmem_we) r_alu <= bus.dmem_rdata;
                S_WB: begin
                    r_pc <= r_npc;
                    if (w_wen) r_regs[w_rd] <= r_alu;
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

    // r_alu holds the effective address for the whole MEM state, so the bus stays stable
    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_req ? r_alu : {XLEN{1'b0}};
    assign bus.dmem_wdata = r_dmem_req ? r_b : {XLEN{1'b0}};
    assign pc             = r_pc;
    assign retire         = r_retire;
    assign halted         = r_halted;
endmodule
